// File: rtl/conv2_accumulator.sv
// conv2_accumulator: conv2 MAC/accumulate stage. Accumulates a 5x5x3
// window per output channel, adds bias, rescales by FRAC_BITS, saturates.
// Optional fused ReLU on the result when CONV2_RELU_EN is defined.
// Ports:
//   clk, n_reset       clock, async active-low reset
//   start              layer enable (level), shared with kernel ROM
//   pix_valid, pix_in  one tap for all 3 input channels
//   weight_conv2_1..3  per-output-channel weights, [i] = input channel
//   bias_conv2         per-output-channel bias
//   ready              tap accepted this cycle (drives ROM ready)
//   out_valid/ready    result handshake toward pooling stage
//   conv2_out          saturated result per output channel
//   tap_cnt, win_cnt   taps in current window, windows handed off
module conv2_accumulator #(
   parameter int FRAC_BITS = 8,
   parameter int TAPS      = 25,
   parameter int ACC_W     = 40
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             start,
   input  logic             pix_valid,
   input  logic [3:1][15:0] pix_in,
   input  logic [3:1][15:0] weight_conv2_1,
   input  logic [3:1][15:0] weight_conv2_2,
   input  logic [3:1][15:0] weight_conv2_3,
   input  logic [3:1][15:0] bias_conv2,
   output logic             ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:1][15:0] conv2_out,
   output logic [4:0]       tap_cnt,
   output logic [15:0]      win_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      FINAL,
      HOLD
   } state_t;

   localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   state_t                  state_q;
   logic signed [ACC_W-1:0] acc_q [3:1];
   logic signed [ACC_W-1:0] acc_d [3:1];
   logic [4:0]              tap_q;
   logic [15:0]             win_q;
   logic                    ovalid_q;
   logic [3:1][15:0]        out_q;
   logic [3:1][15:0]        res_d;
   logic [3:1][3:1][15:0]   w_all;
   logic signed [ACC_W-1:0] biased;
   logic signed [ACC_W-1:0] shifted;

   // w_all[k][i]: weight for output channel k, input channel i
   assign w_all = {weight_conv2_3, weight_conv2_2, weight_conv2_1};

   // Never depends on out_ready so the ROM sees a clean accept strobe
   assign ready = (state_q == ACC) & start & pix_valid;

   assign out_valid = ovalid_q;
   assign conv2_out = out_q;
   assign tap_cnt   = tap_q;
   assign win_cnt   = win_q;

   // Next accumulator value if the current tap is accepted
   always_comb begin
      for (int k = 1; k <= 3; k++) begin
         acc_d[k] = acc_q[k];
         for (int i = 1; i <= 3; i++) begin
            acc_d[k] = acc_d[k] + ACC_W'(
               32'($signed(pix_in[i])) *
               32'($signed(w_all[k][i])));
         end
      end
   end

   // Bias is aligned to the product scale (2*FRAC_BITS) before rescaling
   always_comb begin
      biased  = '0;
      shifted = '0;
      res_d   = '0;
      for (int k = 1; k <= 3; k++) begin
         biased = acc_q[k] +
            (ACC_W'($signed(bias_conv2[k])) <<< FRAC_BITS);
         shifted = biased >>> FRAC_BITS;
         if (shifted > SAT_MAX) begin
            res_d[k] = 16'h7FFF;
         end else if (shifted < SAT_MIN) begin
            res_d[k] = 16'h8000;
         end else begin
            res_d[k] = shifted[15:0];
         end
`ifdef CONV2_RELU_EN
         if (res_d[k][15]) begin
            res_d[k] = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q  <= IDLE;
         tap_q    <= '0;
         win_q    <= '0;
         ovalid_q <= 1'b0;
         out_q    <= '0;
         for (int k = 1; k <= 3; k++) begin
            acc_q[k] <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= ACC;
                  tap_q   <= '0;
                  for (int k = 1; k <= 3; k++) begin
                     acc_q[k] <= '0;
                  end
               end
            end
            ACC: begin
               if (!start) begin
                  // Abort: partial window is dropped
                  state_q <= IDLE;
                  tap_q   <= '0;
                  for (int k = 1; k <= 3; k++) begin
                     acc_q[k] <= '0;
                  end
               end else if (pix_valid) begin
                  for (int k = 1; k <= 3; k++) begin
                     acc_q[k] <= acc_d[k];
                  end
                  if (tap_q == LAST_TAP) begin
                     tap_q   <= '0;
                     state_q <= FINAL;
                  end else begin
                     tap_q <= tap_q + 5'd1;
                  end
               end
            end
            FINAL: begin
               out_q    <= res_d;
               ovalid_q <= 1'b1;
               state_q  <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  ovalid_q <= 1'b0;
                  win_q    <= win_q + 16'd1;
                  for (int k = 1; k <= 3; k++) begin
                     acc_q[k] <= '0;
                  end
                  state_q <= start ? ACC : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
